// File: rtl/score_bcd_ctrl_if.sv
// Score sequencer bus: game-side inputs and BCD digit outputs.
// The hiscore/show_hi pair exists only when HISCORE_EN is defined.
interface score_bcd_ctrl_if #(
    parameter int SCORE_W = 14
);
    logic               score_get;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic [3:0]         bcd3;
    logic [3:0]         bcd2;
    logic [3:0]         bcd1;
    logic [3:0]         bcd0;
    logic               busy;
    logic               bcd_valid;
`ifdef HISCORE_EN
    logic               show_hi;
    logic [SCORE_W-1:0] hiscore;

    modport master (
        output score_get, game_state, show_hi,
        input  score, bcd3, bcd2, bcd1, bcd0,
        input  busy, bcd_valid, hiscore
    );
    modport slave (
        input  score_get, game_state, show_hi,
        output score, bcd3, bcd2, bcd1, bcd0,
        output busy, bcd_valid, hiscore
    );
`else
    modport master (
        output score_get, game_state,
        input  score, bcd3, bcd2, bcd1, bcd0,
        input  busy, bcd_valid
    );
    modport slave (
        input  score_get, game_state,
        output score, bcd3, bcd2, bcd1, bcd0,
        output busy, bcd_valid
    );
`endif
endinterface

// File: rtl/score_bcd_ctrl.sv
// Saturating score counter with iterative double-dabble BCD conversion.
// Optional high-score register enabled by defining HISCORE_EN.
module score_bcd_ctrl #(
    parameter int unsigned  MAX_SCORE      = 9999,
    parameter int           SCORE_W        = 14,
    parameter logic [1:0]   PLAY_STATE     = 2'b01,
    parameter logic [1:0]   GAMEOVER_STATE = 2'b11
) (
    input  logic            clk,
    input  logic            reset,
    score_bcd_ctrl_if.slave bus
);
    localparam int SR_W = SCORE_W + 16;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic               score_get_q;
    logic [1:0]         game_state_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               dirty_q, dirty_set;
    logic [SR_W-1:0]    sr_q, sr_sh;
    logic [3:0]         iter_q;
    logic [15:0]        bcd_q;
    logic               valid_q;
    logic               busy;
    logic               rise, new_game, inc_ok, last;
    logic [SCORE_W-1:0] src;

    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[SCORE_W+4*i +: 4] >= 4'd5)
                t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
    logic               show_hi_q;
    logic               go_entry;

    always_comb begin
        go_entry = (bus.game_state == GAMEOVER_STATE)
                && (game_state_q != GAMEOVER_STATE);
        src = bus.show_hi ? hiscore_q : score_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore_q <= '0;
            show_hi_q <= 1'b0;
        end else begin
            show_hi_q <= bus.show_hi;
            if (go_entry && score_q > hiscore_q)
                hiscore_q <= score_q;
        end
    end

    assign bus.hiscore = hiscore_q;
`else
    assign src = score_q;
`endif

    always_comb begin
        rise     = bus.score_get & ~score_get_q;
        new_game = (bus.game_state == PLAY_STATE)
                && (game_state_q != PLAY_STATE);
        // Saturated increments change nothing, so they must not dirty.
        inc_ok   = rise
                && (bus.game_state != GAMEOVER_STATE)
                && (score_q != SCORE_W'(MAX_SCORE));
        score_d  = score_q;
        if (new_game)
            score_d = '0;
        else if (inc_ok)
            score_d = score_q + 1'b1;
        dirty_set = new_game | inc_ok;
`ifdef HISCORE_EN
        dirty_set = dirty_set | (bus.show_hi ^ show_hi_q);
`endif
        sr_sh = dabble(sr_q);
        last  = (iter_q == 4'(SCORE_W - 1));
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            IDLE:  if (dirty_q) state_d = LOAD;
            LOAD:  begin
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_get_q  <= 1'b0;
            game_state_q <= 2'b00;
            score_q      <= '0;
            dirty_q      <= 1'b0;
            sr_q         <= '0;
            iter_q       <= '0;
            bcd_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            score_get_q  <= bus.score_get;
            game_state_q <= bus.game_state;
            score_q      <= score_d;
            valid_q      <= 1'b0;
            if (dirty_set)
                dirty_q <= 1'b1;
            else if (state_q == LOAD)
                dirty_q <= 1'b0;
            if (state_q == LOAD) begin
                sr_q   <= {16'd0, src};
                iter_q <= '0;
            end
            // Digits land on the final shift so they are live in DONE.
            if (state_q == SHIFT) begin
                sr_q   <= sr_sh;
                iter_q <= iter_q + 1'b1;
                if (last) begin
                    bcd_q   <= sr_sh[SR_W-1 -: 16];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.score     = score_q;
    assign bus.bcd3      = bcd_q[15:12];
    assign bus.bcd2      = bcd_q[11:8];
    assign bus.bcd1      = bcd_q[7:4];
    assign bus.bcd0      = bcd_q[3:0];
    assign bus.busy      = busy;
    assign bus.bcd_valid = valid_q;
endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Bench for score_bcd_ctrl: vector table, scoreboard of published
// digits, and hand sequences for latency, coalescing and saturation.
module tb_score_bcd_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    score_bcd_ctrl_if #(.SCORE_W(14)) bus ();

    score_bcd_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        get;
        logic [1:0]  gs;
        logic [13:0] score;
        logic        pub;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] q[$];
    int          tests = 0;
    int          errors = 0;
    int          pubs = 0;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int digits();
        return int'({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0});
    endfunction

    task automatic drain(input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.bcd_valid) begin
                pubs++;
                if (q.size() == 0) begin
                    chk("unexpected_publish", digits(), 0);
                    if (digits() == 0) begin
                        errors++;
                        $display("FAIL unexpected_publish: got 0 want none");
                    end
                end else begin
                    e = q.pop_front();
                    chk("publish_digits", digits(), int'(e));
                end
            end
        end
    endtask

    task automatic pulse();
        bus.score_get = 1'b1;
        drain(1);
        bus.score_get = 1'b0;
        drain(1);
    endtask

    task automatic pulse_fast(input int n);
        for (int i = 0; i < n; i++) begin
            bus.score_get = 1'b1;
            tick();
            bus.score_get = 1'b0;
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        q.delete();
        pubs = 0;
    endtask

    initial begin
        bus.score_get  = 1'b0;
        bus.game_state = 2'b00;
`ifdef HISCORE_EN
        bus.show_hi    = 1'b0;
`endif
        vecs[0] = '{1'b1, 2'b00, 14'd1, 1'b1};
        vecs[1] = '{1'b0, 2'b01, 14'd0, 1'b1};
        vecs[2] = '{1'b1, 2'b01, 14'd1, 1'b1};
        vecs[3] = '{1'b1, 2'b01, 14'd2, 1'b1};
        vecs[4] = '{1'b0, 2'b10, 14'd2, 1'b0};
        vecs[5] = '{1'b1, 2'b10, 14'd3, 1'b1};
        vecs[6] = '{1'b1, 2'b11, 14'd3, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 14'd0, 1'b1};
        vecs[8] = '{1'b1, 2'b01, 14'd1, 1'b1};

        do_reset();
        chk("rst_score", int'(bus.score), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.bcd_valid), 0);
        chk("rst_digits", digits(), 0);

        // Single pulse: exact latency and busy window.
        bus.score_get = 1'b1;
        tick();
        bus.score_get = 1'b0;
        chk("lat_score", int'(bus.score), 1);
        chk("lat_busy0", int'(bus.busy), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("lat_busy_%0d", k),
                int'(bus.busy), (k <= 15) ? 1 : 0);
            chk($sformatf("lat_valid_%0d", k),
                int'(bus.bcd_valid), (k == 16) ? 1 : 0);
        end
        chk("lat_digits", digits(), 16'h0001);
        tick();
        chk("lat_valid_off", int'(bus.bcd_valid), 0);

        // Held-high input scores once.
        q.push_back(to_bcd(2));
        bus.score_get = 1'b1;
        drain(100);
        bus.score_get = 1'b0;
        drain(20);
        chk("held_score", int'(bus.score), 2);
        chk("held_pubs", pubs, 1);
        chk("held_q_empty", q.size(), 0);

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].pub) q.push_back(to_bcd(int'(vecs[i].score)));
            bus.score_get  = vecs[i].get;
            bus.game_state = vecs[i].gs;
            drain(1);
            bus.score_get = 1'b0;
            drain(20);
            chk($sformatf("vec%0d_score", i),
                int'(bus.score), int'(vecs[i].score));
        end
        chk("vec_q_empty", q.size(), 0);

        // Second change mid-conversion: stale publish then the fresh one.
        do_reset();
        bus.game_state = 2'b00;
        pulse_fast(41);
        idle(40);
        chk("mid_pre_score", int'(bus.score), 41);
        pubs = 0;
        q.push_back(to_bcd(42));
        bus.score_get = 1'b1;
        drain(1);
        bus.score_get = 1'b0;
        drain(4);
        q.push_back(to_bcd(43));
        bus.score_get = 1'b1;
        drain(1);
        bus.score_get = 1'b0;
        drain(50);
        chk("mid_pubs", pubs, 2);
        chk("mid_score", int'(bus.score), 43);
        chk("mid_q_empty", q.size(), 0);

        // Reset in the middle of a conversion.
        bus.score_get = 1'b1;
        tick();
        bus.score_get = 1'b0;
        idle(9);
        chk("rmid_busy_pre", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        chk("rmid_score", int'(bus.score), 0);
        chk("rmid_busy", int'(bus.busy), 0);
        chk("rmid_digits", digits(), 0);
        chk("rmid_valid", int'(bus.bcd_valid), 0);
        reset = 1'b0;
        pubs = 0;
        drain(30);
        chk("rmid_no_pub", pubs, 0);

        // Saturation at the ceiling.
        do_reset();
        pulse_fast(9998);
        idle(40);
        chk("sat_pre", int'(bus.score), 9998);
        pubs = 0;
        q.push_back(to_bcd(9999));
        for (int i = 0; i < 3; i++) pulse();
        drain(60);
        chk("sat_score", int'(bus.score), 9999);
        chk("sat_pubs", pubs, 1);
        chk("sat_digits", digits(), 16'h9999);
        chk("sat_q_empty", q.size(), 0);

`ifdef HISCORE_EN
        do_reset();
        bus.game_state = 2'b01;
        idle(2);
        pulse_fast(120);
        idle(40);
        bus.game_state = 2'b11;
        idle(3);
        chk("hi_first", int'(bus.hiscore), 120);
        bus.game_state = 2'b01;
        idle(2);
        pulse_fast(80);
        idle(40);
        bus.game_state = 2'b11;
        idle(3);
        chk("hi_kept", int'(bus.hiscore), 120);
        chk("hi_score", int'(bus.score), 80);
        pubs = 0;
        q.push_back(to_bcd(120));
        bus.show_hi = 1'b1;
        drain(30);
        chk("hi_pubs", pubs, 1);
        chk("hi_digits", digits(), 16'h0120);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
